// File: rtl/arb_byte_bridge.sv
// Word FIFO + 32-to-8 serialiser between readout arbiter and byte TX FIFO.
// Optional statistics counters: define ARB_BRIDGE_STATS_EN.
module arb_byte_bridge #(
  parameter int DEPTH      = 16,
  parameter int BYTE_ORDER = 0
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST_N,
  input  logic        ARB_WRITE_IN,
  input  logic [31:0] ARB_DATA_IN,
  output logic        ARB_READY_OUT,
  input  logic        TX_FULL,
  output logic        TX_WR,
  output logic [7:0]  TX_DATA,
`ifdef ARB_BRIDGE_STATS_EN
  output logic [31:0] WORD_CNT,
  output logic [15:0] OVERFLOW_CNT,
  output logic        OVERFLOW,
  input  logic        STATS_CLR,
`endif
  output logic        BUSY
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, B0, B1, B2, B3
  } state_e;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] fill;
  state_e        state_q, state_d;
  logic [31:0]   shift_q, shift_d;
  logic          tx_wr_q, tx_wr_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          full, empty, push, pop;
  logic [1:0]    byte_idx;
  logic [7:0]    cur_byte;

  assign fill  = wr_ptr_q - rd_ptr_q;
  assign full  = (fill == PW'(DEPTH));
  assign empty = (fill == '0);
  assign push  = ARB_WRITE_IN & ~full;

  assign ARB_READY_OUT = ~full;
  assign BUSY          = ~empty | (state_q != IDLE);
  assign TX_WR         = tx_wr_q;
  assign TX_DATA       = tx_data_q;

  always_comb begin
    byte_idx = 2'd0;
    case (state_q)
      B1:      byte_idx = 2'd1;
      B2:      byte_idx = 2'd2;
      B3:      byte_idx = 2'd3;
      default: byte_idx = 2'd0;
    endcase
  end

  always_comb begin
    if (BYTE_ORDER == 0)
      cur_byte = shift_q[{byte_idx, 3'b000} +: 8];
    else
      cur_byte = shift_q[{~byte_idx, 3'b000} +: 8];
  end

  // B3 acceptance may reload directly so words stream without an IDLE bubble
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    tx_wr_d   = 1'b0;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q[AW-1:0]];
          state_d = B0;
        end
      end
      B0, B1, B2: begin
        if (!TX_FULL) begin
          tx_wr_d   = 1'b1;
          tx_data_d = cur_byte;
          state_d   = state_e'(state_q + 3'd1);
        end
      end
      B3: begin
        if (!TX_FULL) begin
          tx_wr_d   = 1'b1;
          tx_data_d = cur_byte;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q[AW-1:0]];
            state_d = B0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_ptr_d = wr_ptr_q + PW'(push);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);

  always_ff @(posedge BUS_CLK) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= ARB_DATA_IN;
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      state_q   <= IDLE;
      shift_q   <= '0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      tx_wr_q   <= tx_wr_d;
      tx_data_q <= tx_data_d;
    end
  end

`ifdef ARB_BRIDGE_STATS_EN
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
  logic        ovf_q, ovf_d;
  logic        word_done, drop;

  assign word_done = (state_q == B3) & ~TX_FULL;
  assign drop      = ARB_WRITE_IN & full;

  always_comb begin
    word_cnt_d = word_cnt_q + 32'(word_done);
    ovf_cnt_d  = ovf_cnt_q;
    ovf_d      = ovf_q | drop;
    if (drop && ovf_cnt_q != 16'hFFFF)
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    if (STATS_CLR) begin
      word_cnt_d = '0;
      ovf_cnt_d  = '0;
      ovf_d      = 1'b0;
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      word_cnt_q <= '0;
      ovf_cnt_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      word_cnt_q <= word_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign WORD_CNT     = word_cnt_q;
  assign OVERFLOW_CNT = ovf_cnt_q;
  assign OVERFLOW     = ovf_q;
`endif

endmodule

// File: tb/tb_arb_byte_bridge.sv
// Scoreboard bench for arb_byte_bridge (DEPTH=16, LSB-first).
// Stats ports connected when ARB_BRIDGE_STATS_EN is defined.
module tb_arb_byte_bridge;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] din = '0;
  logic        rdy;
  logic        tx_full = 1'b0;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic        busy;
`ifdef ARB_BRIDGE_STATS_EN
  logic [31:0] word_cnt;
  logic [15:0] ovf_cnt;
  logic        ovf;
  logic        stats_clr = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int tx_count = 0;
  logic full_last = 1'b0;
  logic [7:0] expq[$];

  arb_byte_bridge #(.DEPTH(DEPTH), .BYTE_ORDER(0)) dut (
    .BUS_CLK      (clk),
    .BUS_RST_N    (rst_n),
    .ARB_WRITE_IN (wr),
    .ARB_DATA_IN  (din),
    .ARB_READY_OUT(rdy),
    .TX_FULL      (tx_full),
    .TX_WR        (tx_wr),
    .TX_DATA      (tx_data),
`ifdef ARB_BRIDGE_STATS_EN
    .WORD_CNT     (word_cnt),
    .OVERFLOW_CNT (ovf_cnt),
    .OVERFLOW     (ovf),
    .STATS_CLR    (stats_clr),
`endif
    .BUSY         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) full_last = tx_full;

  always @(negedge clk) begin
    if (rst_n && tx_wr) begin
      tx_count++;
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got=%02h", tx_data);
      end else begin
        logic [7:0] e;
        e = expq.pop_front();
        if (tx_data !== e) begin
          failures++;
          $display("FAIL sb_byte got=%02h exp=%02h", tx_data, e);
        end
      end
      checks++;
      if (full_last) begin
        failures++;
        $display("FAIL wr_while_full got=1 exp=0");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_word(input logic [31:0] w);
    expq.push_back(w[7:0]);
    expq.push_back(w[15:8]);
    expq.push_back(w[23:16]);
    expq.push_back(w[31:24]);
  endtask

  task automatic push_word(input logic [31:0] w);
    int n = 0;
    while (!rdy && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL push_timeout got=0 exp=1");
    end
    wr  = 1'b1;
    din = w;
    exp_word(w);
    tick();
    wr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL idle_timeout got=1 exp=0");
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({tx_wr, tx_data, busy, rdy} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b",
               {tx_wr, tx_data, busy, rdy}, {1'b0, 8'h00, 1'b0, 1'b1});
    end
`ifdef ARB_BRIDGE_STATS_EN
    checks++;
    if ({word_cnt, ovf_cnt, ovf} !== 49'd0) begin
      failures++;
      $display("FAIL reset_stats got=%h exp=0", {word_cnt, ovf_cnt, ovf});
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] eb[4];
    int k = 0;
    eb = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    push_word(32'hA1B2C3D4);
    for (int i = 1; i <= 6; i++) begin
      logic e;
      tick();
      e = (i >= 2 && i <= 5);
      checks++;
      if (tx_wr !== e) begin
        failures++;
        $display("FAIL single_wr c%0d got=%b exp=%b", i, tx_wr, e);
      end
      if (e) begin
        checks++;
        if (tx_data !== eb[k]) begin
          failures++;
          $display("FAIL single_data got=%02h exp=%02h", tx_data, eb[k]);
        end
        k++;
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_busy got=%b exp=0", busy);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int run = 0;
    push_word(32'h11223344);
    push_word(32'h55667788);
    push_word(32'h99AABBCC);
    while (!tx_wr && n < 50) begin
      tick();
      n++;
    end
    while (tx_wr && run < 20) begin
      run++;
      tick();
    end
    checks++;
    if (run != 12) begin
      failures++;
      $display("FAIL b2b_run got=%0d exp=12", run);
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    int c0 = tx_count;
    push_word(32'hDEADBEEF);
    tick();
    tick();
    tx_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (tx_wr !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall c%0d got=%b exp=0", i, tx_wr);
      end
    end
    tx_full = 1'b0;
    wait_idle();
    checks++;
    if (tx_count - c0 != 4) begin
      failures++;
      $display("FAIL bp_bytes got=%0d exp=4", tx_count - c0);
    end
  endtask

  task automatic test_overflow();
    int c0 = tx_count;
    tx_full = 1'b1;
    push_word(32'h0F0F0000);
    tick();
    for (int k = 0; k < DEPTH + 2; k++) begin
      logic er;
      logic [31:0] w;
      er = (k < DEPTH);
      w  = 32'h0F0F0100 + k;
      checks++;
      if (rdy !== er) begin
        failures++;
        $display("FAIL ovf_ready k%0d got=%b exp=%b", k, rdy, er);
      end
      wr  = 1'b1;
      din = w;
      if (er) exp_word(w);
      tick();
    end
    wr = 1'b0;
`ifdef ARB_BRIDGE_STATS_EN
    checks++;
    if (ovf_cnt !== 16'd2 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_stats got=%0d/%b exp=2/1", ovf_cnt, ovf);
    end
`endif
    tx_full = 1'b0;
    wait_idle();
    checks++;
    if (tx_count - c0 != 4 * (DEPTH + 1)) begin
      failures++;
      $display("FAIL ovf_bytes got=%0d exp=%0d",
               tx_count - c0, 4 * (DEPTH + 1));
    end
`ifdef ARB_BRIDGE_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    checks++;
    if ({word_cnt, ovf_cnt, ovf} !== 49'd0) begin
      failures++;
      $display("FAIL stats_clr got=%h exp=0", {word_cnt, ovf_cnt, ovf});
    end
`endif
  endtask

  task automatic test_wrap();
    int c0;
    tx_full = 1'b1;
    push_word(32'hCAFE0000);
    tick();
    for (int k = 1; k < DEPTH; k++) push_word(32'hCAFE0000 + k);
    tx_full = 1'b0;
    tick();
    tick();
    tick();
    tx_full = 1'b1;
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL wrap_pre_ready got=%b exp=1", rdy);
    end
    wr  = 1'b1;
    din = 32'hCAFE0100;
    exp_word(32'hCAFE0100);
    tx_full = 1'b0;
    tick();
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL wrap_pushpop_ready got=%b exp=1", rdy);
    end
    din = 32'hCAFE0101;
    exp_word(32'hCAFE0101);
    tick();
    wr = 1'b0;
    checks++;
    if (rdy !== 1'b0) begin
      failures++;
      $display("FAIL wrap_full_ready got=%b exp=0", rdy);
    end
    wait_idle();
    c0 = tx_count;
    for (int i = 0; i < 3 * DEPTH; i++) push_word($urandom);
    wait_idle();
    checks++;
    if (tx_count - c0 != 12 * DEPTH || expq.size() != 0) begin
      failures++;
      $display("FAIL wrap_bytes got=%0d exp=%0d",
               tx_count - c0, 12 * DEPTH);
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    push_word(32'h01020304);
    push_word(32'h05060708);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_wr, busy, rdy} !== 3'b001) begin
      failures++;
      $display("FAIL rst_mid got=%b exp=001", {tx_wr, busy, rdy});
    end
    expq.delete();
    c0 = tx_count;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (tx_count != c0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_quiet got=%0d/%b exp=%0d/0",
               tx_count, busy, c0);
    end
    push_word(32'h0A0B0C0D);
    wait_idle();
    checks++;
    if (tx_count - c0 != 4) begin
      failures++;
      $display("FAIL rst_after got=%0d exp=4", tx_count - c0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_wrap();
    test_reset_mid();
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d exp=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
